// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU core and a DMA/loader engine.
// Grants are combinational from requests plus registered lock/starvation state.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned LOCK_MAX   = 16
) (
    input  logic        cclk,
    input  logic        rstb,

    input  logic        cpu_req,
    input  logic        cpu_wr_ena,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wr_data,
    output logic        cpu_gnt,
    output logic [31:0] cpu_rd_data,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic        dma_wr_ena,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wr_data,
    output logic        dma_gnt,
    output logic [31:0] dma_rd_data,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_ena,
    input  logic [31:0] mem_rd_data
);

    // Handshake: a requester holds *_req (and its address/data) high for a
    // cycle; the beat completes in that cycle iff its *_gnt is high, with
    // writes sampled by memory on the closing rising edge.

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [8:0] LOCK_LIM   = 9'(LOCK_MAX);

    // ST_LOCKED and ST_FORCE are mutually exclusive, so the locked and
    // force_cpu bits are carried as one encoded arbitration mode.
    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FORCE  = 2'd2
    } arb_state_t;

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [7:0] r_starve_cnt;
    logic [7:0] w_starve_cnt_nxt;
    logic [7:0] r_lock_cnt;
    logic [7:0] w_lock_cnt_nxt;

    logic       w_locked;
    logic       w_force_cpu;
    logic       w_cpu_gnt;
    logic       w_dma_gnt;
    logic [8:0] w_lock_cnt_inc;

    assign w_locked       = (r_state == ST_LOCKED);
    assign w_force_cpu    = (r_state == ST_FORCE);
    assign w_lock_cnt_inc = {1'b0, r_lock_cnt} + 9'd1;

    // Grant decision; arbitration only matters under contention.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (cpu_req && dma_req) begin
            if (w_force_cpu) begin
                w_cpu_gnt = 1'b1;
            end else if (w_locked) begin
                w_dma_gnt = 1'b1;
            end else if (r_starve_cnt == STARVE_LIM) begin
                w_dma_gnt = 1'b1;
            end else begin
                w_cpu_gnt = 1'b1;
            end
        end else begin
            w_cpu_gnt = cpu_req;
            w_dma_gnt = dma_req;
        end
    end

    // Arbitration mode and burst length tracking.
    always_comb begin
        w_state_nxt    = (r_state == ST_FORCE) ? ST_OPEN : r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        if (!dma_req) begin
            w_state_nxt    = ST_OPEN;
            w_lock_cnt_nxt = 8'd0;
        end else if (w_dma_gnt) begin
            if (!dma_lock) begin
                w_state_nxt    = ST_OPEN;
                w_lock_cnt_nxt = 8'd0;
            end else if (!w_locked) begin
                w_state_nxt    = ST_LOCKED;
                w_lock_cnt_nxt = 8'd1;
            end else if (w_lock_cnt_inc >= LOCK_LIM) begin
                // Burst hit its ceiling: hand the next contended beat to the CPU.
                w_state_nxt    = ST_FORCE;
                w_lock_cnt_nxt = 8'd0;
            end else begin
                w_lock_cnt_nxt = w_lock_cnt_inc[7:0];
            end
        end
    end

    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (!dma_req || w_dma_gnt) begin
            w_starve_cnt_nxt = 8'd0;
        end else if (w_cpu_gnt && (r_starve_cnt < STARVE_LIM)) begin
            w_starve_cnt_nxt = r_starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            r_state      <= ST_OPEN;
            r_starve_cnt <= 8'd0;
            r_lock_cnt   <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
        end
    end

    // Port mux; read data is steered only by the grant, never fed back.
    always_comb begin
        mem_addr    = 32'h0;
        mem_wr_data = 32'h0;
        mem_wr_ena  = 1'b0;
        if (w_cpu_gnt) begin
            mem_addr    = cpu_addr;
            mem_wr_data = cpu_wr_data;
            mem_wr_ena  = cpu_wr_ena;
        end else if (w_dma_gnt) begin
            mem_addr    = dma_addr;
            mem_wr_data = dma_wr_data;
            mem_wr_ena  = dma_wr_ena;
        end
    end

    assign cpu_gnt     = w_cpu_gnt;
    assign dma_gnt     = w_dma_gnt;
    assign cpu_stall   = cpu_req & ~w_cpu_gnt;
    assign cpu_rd_data = w_cpu_gnt ? mem_rd_data : 32'h0;
    assign dma_rd_data = w_dma_gnt ? mem_rd_data : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand-written
// starvation, burst-lock, lock-ceiling, mid-burst reset and idle sequences.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 8;
    localparam int LOCK_MAX   = 16;

    logic        cclk = 1'b0;
    logic        rstb = 1'b0;
    logic        cpu_req, cpu_wr_ena;
    logic [31:0] cpu_addr, cpu_wr_data;
    logic        cpu_gnt, cpu_stall;
    logic [31:0] cpu_rd_data;
    logic        dma_req, dma_lock, dma_wr_ena;
    logic [31:0] dma_addr, dma_wr_data;
    logic        dma_gnt;
    logic [31:0] dma_rd_data;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic        mem_wr_ena;

    always #5 cclk = ~cclk;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) dut (
        .cclk(cclk), .rstb(rstb),
        .cpu_req(cpu_req), .cpu_wr_ena(cpu_wr_ena), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_gnt(cpu_gnt), .cpu_rd_data(cpu_rd_data),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_wr_ena(dma_wr_ena),
        .dma_addr(dma_addr), .dma_wr_data(dma_wr_data), .dma_gnt(dma_gnt),
        .dma_rd_data(dma_rd_data),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
        .mem_rd_data(mem_rd_data)
    );

    // owner: 0 = nobody, 1 = CPU, 2 = DMA
    typedef struct {
        string       name;
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dl, dw;
        logic [31:0] da, dd;
        int          owner;
    } vec_t;

    logic [131:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic clear_inputs();
        cpu_req = 1'b0; cpu_wr_ena = 1'b0; cpu_addr = 32'h0; cpu_wr_data = 32'h0;
        dma_req = 1'b0; dma_lock = 1'b0; dma_wr_ena = 1'b0;
        dma_addr = 32'h0; dma_wr_data = 32'h0; mem_rd_data = 32'h0;
    endtask

    // Expected output bundle given who should own the port this cycle.
    function automatic logic [131:0] exp_vec(input int owner);
        logic        cg, dg, we;
        logic [31:0] a, w, crd, drd;
        cg  = (owner == 1);
        dg  = (owner == 2);
        a   = cg ? cpu_addr    : (dg ? dma_addr    : 32'h0);
        w   = cg ? cpu_wr_data : (dg ? dma_wr_data : 32'h0);
        we  = cg ? cpu_wr_ena  : (dg ? dma_wr_ena  : 1'b0);
        crd = cg ? mem_rd_data : 32'h0;
        drd = dg ? mem_rd_data : 32'h0;
        return {cg, dg, cpu_req & ~cg, we, a, w, crd, drd};
    endfunction

    // Inputs are already driven; push expectation, compare at negedge,
    // then step to just after the next rising edge.
    task automatic cycle(input string name, input int owner);
        logic [131:0] e, act;
        string        n;
        mem_rd_data = $urandom();
        exp_q.push_back(exp_vec(owner));
        name_q.push_back(name);
        @(negedge cclk);
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        act = {cpu_gnt, dma_gnt, cpu_stall, mem_wr_ena, mem_addr, mem_wr_data,
               cpu_rd_data, dma_rd_data};
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, act, e);
        @(posedge cclk);
        #1;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        clear_inputs();
        @(posedge cclk);
        #1;
        cycle("reset_idle", 0);
        cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b1;
        cycle("reset_both_req", 1);
        clear_inputs();
        rstb = 1'b1;
    endtask

    task automatic rand_payload();
        cpu_wr_ena = 1'($urandom_range(0, 1));
        dma_wr_ena = 1'($urandom_range(0, 1));
        cpu_addr = $urandom(); cpu_wr_data = $urandom();
        dma_addr = $urandom(); dma_wr_data = $urandom();
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"idle",       0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0,    32'h0,        0};
        vecs[1] = '{"cpu_rd",     1, 0, 32'h00400000, 32'h0,        0, 0, 0, 32'h0,    32'h0,        1};
        vecs[2] = '{"cpu_wr",     1, 1, 32'h00400004, 32'hDEADBEEF, 0, 0, 0, 32'h0,    32'h0,        1};
        vecs[3] = '{"dma_wr",     0, 0, 32'h0,        32'h0,        1, 0, 1, 32'h2000, 32'h12345678, 2};
        vecs[4] = '{"dma_rd",     0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h2004, 32'h0,        2};
        vecs[5] = '{"contend_a",  1, 1, 32'h00400008, 32'hA5A5A5A5, 1, 0, 1, 32'h2008, 32'h5A5A5A5A, 1};
        vecs[6] = '{"contend_b",  1, 0, 32'h0040000C, 32'h0,        1, 0, 0, 32'h200C, 32'h0,        1};
        vecs[7] = '{"cpu_alone",  1, 1, 32'h00400010, 32'h01020304, 0, 1, 1, 32'h2010, 32'h0,        1};
        vecs[8] = '{"idle_again", 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0,    32'h0,        0};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            cpu_req = vecs[i].cr; cpu_wr_ena = vecs[i].cw;
            cpu_addr = vecs[i].ca; cpu_wr_data = vecs[i].cd;
            dma_req = vecs[i].dr; dma_lock = vecs[i].dl; dma_wr_ena = vecs[i].dw;
            dma_addr = vecs[i].da; dma_wr_data = vecs[i].dd;
            cycle(vecs[i].name, vecs[i].owner);
        end

        // Starvation: DMA wins every STARVE_MAX+1 th contended cycle.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b0;
            rand_payload();
            cycle($sformatf("starve_c%0d", i), (i == 8 || i == 17) ? 2 : 1);
        end

        // Four-beat locked DMA burst under contention, then CPU.
        do_reset();
        dma_req = 1'b1; dma_lock = 1'b1; dma_wr_ena = 1'b1;
        cpu_wr_ena = 1'b0; cpu_addr = 32'h00400000;
        for (int i = 0; i < 4; i++) begin
            cpu_req     = (i != 0);
            dma_lock    = (i != 3);
            dma_addr    = 32'h1000 + 32'(4 * i);
            dma_wr_data = $urandom();
            cycle($sformatf("burst_b%0d", i), 2);
        end
        dma_addr = 32'h1010;
        cycle("burst_then_cpu", 1);

        // Lock ceiling: 16 DMA beats, forced CPU beat, starve back to DMA lock.
        do_reset();
        dma_req = 1'b1; dma_lock = 1'b1;
        for (int i = 0; i < 26; i++) begin
            cpu_req = (i != 0);
            dma_lock = 1'b1;
            rand_payload();
            cycle($sformatf("lockmax_c%0d", i), (i < 16 || i >= 24) ? 2 : 1);
        end

        // Reset asserted in the middle of a locked burst.
        do_reset();
        dma_req = 1'b1; dma_lock = 1'b1;
        cycle("midrst_b0", 2);
        cpu_req = 1'b1;
        cycle("midrst_b1", 2);
        cycle("midrst_b2", 2);
        rstb = 1'b0;
        cycle("midrst_in_reset", 1);
        rstb = 1'b1;
        cycle("midrst_after", 1);

        clear_inputs();
        cycle("final_idle", 0);
        cycle("final_idle2", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single memory port between the multicycle CPU core and a DMA/loader engine. Grant is decided combinationally each cycle from the current requests and registered arbitration state, so a granted access completes in the same cycle. It sits between the CPU's memory interface (`mem_addr`, `mem_wr_data`, `mem_wr_ena`, `mem_rd_data`) and the memory. It exports `cpu_stall` so the core can hold its state registers while the DMA owns the port.

## Interface
- STARVE_MAX, 8: max consecutive CPU grants while DMA waits; range 1..255.
- LOCK_MAX, 16: max consecutive locked DMA grants before a forced release; range 1..255.
- cclk  in  1  clock; all state updates on rising edge.
- rstb  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU requests the port this cycle.
- cpu_wr_ena  in  1  CPU write (1) / read (0).
- cpu_addr  in  32  CPU byte address.
- cpu_wr_data  in  32  CPU write data.
- cpu_gnt  out  1  CPU owns the port this cycle.
- cpu_rd_data  out  32  mem_rd_data when cpu_gnt, else 0.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- dma_req  in  1  DMA requests the port.
- dma_lock  in  1  DMA requests to keep ownership after this beat (burst).
- dma_wr_ena  in  1  DMA write/read.
- dma_addr  in  32  DMA byte address.
- dma_wr_data  in  32  DMA write data.
- dma_gnt  out  1  DMA owns the port this cycle.
- dma_rd_data  out  32  mem_rd_data when dma_gnt, else 0.
- mem_addr  out  32  winner's address; 0 when idle.
- mem_wr_data  out  32  winner's write data; 0 when idle.
- mem_wr_ena  out  1  winner's wr_ena & grant; 0 when idle.
- mem_rd_data  in  32  combinational read data from memory.

## Operation
- State: `locked` (1b), `starve_cnt` (8b, saturating at STARVE_MAX), `lock_cnt` (8b), `force_cpu` (1b).
- cpu_gnt and dma_gnt are never both 1. Neither is 1 without its req.
- Grant priority when both request, first match wins:
  1. force_cpu = 1 -> CPU.
  2. locked = 1 -> DMA.
  3. starve_cnt == STARVE_MAX -> DMA.
  4. Otherwise -> CPU.
- A single requester is always granted, including CPU while locked = 1. Lock only has effect under contention.
- starve_cnt update:
  - cpu_gnt & dma_req -> +1, saturating.
  - dma_gnt or ~dma_req -> 0.
  - Otherwise hold.
- Lock entry: dma_gnt & dma_lock & ~locked -> locked <= 1, lock_cnt <= 1.
- Lock continue: dma_gnt & dma_lock & locked -> lock_cnt + 1.
  - If lock_cnt + 1 == LOCK_MAX: locked <= 0, force_cpu <= 1.
- Lock exit:
  - dma_gnt & ~dma_lock -> locked <= 0, lock_cnt <= 0.
  - ~dma_req -> locked <= 0, lock_cnt <= 0.
- force_cpu clears after one cycle, whether or not CPU was granted.
- Write beat: memory samples mem_wr_ena/addr/data on the same rising edge that ends the granted cycle.
- Read beat: data is valid on the *_rd_data output of the granted requester during the granted cycle.

## Timing
- Grant latency: 0 cycles; cpu_gnt/dma_gnt are combinational from req inputs plus registered state.
- State updates take effect on the next rising cclk.
- Reset (rstb low, any time, including mid-burst):
  - locked = 0, force_cpu = 0, starve_cnt = 0, lock_cnt = 0 immediately, without waiting for a clock edge.
  - Outputs then follow the grant rules from the cleared state: grants follow requests with CPU priority. With no requests, all mem_* and *_rd_data outputs are 0 and cpu_stall = 0.
- First grant after rstb deasserts follows the rules with cleared state.
- Simultaneous lock end and LOCK_MAX: ~dma_lock exit takes precedence; force_cpu stays 0.
- No combinational path from mem_rd_data to any grant or mem_* output.

## Test plan
- Reset, then cpu_req = 1 only, cpu_addr = 0x00400000, read. Required: cpu_gnt = 1, mem_addr = 0x00400000, cpu_rd_data = mem_rd_data, cpu_stall = 0, dma_gnt = 0.
- STARVE_MAX = 8; cpu_req and dma_req held high. Required: CPU granted cycles 0-7, DMA cycle 8, CPU cycles 9-16, DMA cycle 17; cpu_stall = 1 only on cycles 8 and 17.
- Contention with dma_lock = 1 for 4 beats (then 0), dma_addr = 0x1000..0x100C. Required: DMA granted 4 consecutive cycles, then CPU on the next cycle; mem_wr_ena mirrors dma_wr_ena only during DMA cycles.
- LOCK_MAX = 16; dma_lock held high with cpu_req high. Required: DMA granted for 16 cycles, CPU granted on cycle 17; locking may then resume per the priority rules.
- Assert rstb low during locked cycle 3, with both requests held. Required: locked clears immediately; after release, CPU is granted on the first cycle.
- Idle (no requests). Required: mem_addr = 0, mem_wr_data = 0, mem_wr_ena = 0, both gnt = 0, both rd_data = 0.
